// File: rtl/bus_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and the memory stage.
// One transaction is outstanding at a time. The memory stage wins ties, and aborted fetches are drained in DROP.
module bus_arbiter #(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_address,
  input  logic        fetch_abort,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        fetch_error,
  input  logic        mem_valid,
  input  logic [31:0] mem_address,
  input  logic        mem_write,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_write_strobe,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        ext_valid,
  output logic [31:0] ext_address,
  output logic        ext_write,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic [31:0] ext_read_data,
  input  logic        ext_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, MEM, DROP} state_t;

  localparam logic [CNT_W-1:0] COUNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [31:0]       fetch_address_q;
  logic              capture_fetch;
  logic              timeout;

  // The timeout fires on the last permitted bus cycle that has no ext_ready.
  assign timeout = (TIMEOUT > 0) && (state != IDLE) && !ext_ready && (count == COUNT_LAST);

  always_comb begin
    state_next       = state;
    capture_fetch    = 1'b0;
    fetch_ready      = 1'b0;
    fetch_error      = 1'b0;
    mem_error        = 1'b0;
    ext_valid        = 1'b0;
    ext_address      = fetch_address_q;
    ext_write        = 1'b0;
    ext_write_data   = '0;
    ext_write_strobe = '0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          state_next = MEM;
        end else if (fetch_valid && !fetch_abort) begin
          state_next    = FETCH;
          capture_fetch = 1'b1;
        end
      end
      FETCH: begin
        ext_valid = 1'b1;
        if (ext_ready || timeout) begin
          state_next = IDLE;
          if (!fetch_abort) begin
            fetch_ready = 1'b1;
            fetch_error = timeout;
          end
        end else if (fetch_abort) begin
          state_next = DROP;
        end
      end
      DROP: begin
        ext_valid = 1'b1;
        if (ext_ready || timeout) begin
          state_next = IDLE;
        end
      end
      MEM: begin
        ext_valid        = 1'b1;
        ext_address      = mem_address;
        ext_write        = mem_write;
        ext_write_data   = mem_write_data;
        ext_write_strobe = mem_write ? mem_write_strobe : 4'b0000;
        if (ext_ready || timeout) begin
          state_next = IDLE;
          mem_error  = timeout;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_ready  = !mem_valid || ((state == MEM) && ext_ready) || mem_error;
  assign fetch_data = ext_read_data;
  assign mem_data   = ext_read_data;

  // The counter restarts on every state change, which also covers entry into DROP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      count           <= '0;
      fetch_address_q <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == IDLE)) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      if (capture_fetch) begin
        fetch_address_q <= fetch_address;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by randomized traffic.
// Every cycle is checked against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TIMEOUT = 4;
  localparam int NONE = 0, OWN_FETCH = 1, OWN_MEM = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid, fetch_abort, mem_valid, mem_write, ext_ready;
  logic [31:0] fetch_address, mem_address, mem_write_data, ext_read_data;
  logic [3:0]  mem_write_strobe;
  logic [31:0] fetch_data, mem_data, ext_address, ext_write_data;
  logic        fetch_ready, fetch_error, mem_ready, mem_error, ext_valid, ext_write;
  logic [3:0]  ext_write_strobe;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_address(fetch_address), .fetch_abort(fetch_abort),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready), .fetch_error(fetch_error),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_write_strobe(mem_write_strobe),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_error(mem_error),
    .ext_valid(ext_valid), .ext_address(ext_address), .ext_write(ext_write),
    .ext_write_data(ext_write_data), .ext_write_strobe(ext_write_strobe),
    .ext_read_data(ext_read_data), .ext_ready(ext_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the outstanding transaction, who owns it, and whether its result is discarded.
  int          owner = NONE;
  bit          dropped = 1'b0;
  int          waited = 0;
  logic [31:0] cap_addr = '0;
  int          nx_owner;
  bit          nx_dropped;
  int          nx_waited;
  logic [31:0] nx_cap;
  bit          e_fetch_ready, e_fetch_error, e_mem_ready, e_mem_error;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model mid-cycle and works out the model's next transaction state.
  task automatic applyStimulus();
    bit tmo, done;
    @(negedge clk);
    tmo  = (owner != NONE) && !ext_ready && (waited == TIMEOUT - 1);
    done = (owner != NONE) && (ext_ready || tmo);
    e_fetch_ready = (owner == OWN_FETCH) && !dropped && !fetch_abort && done;
    e_fetch_error = e_fetch_ready && tmo;
    e_mem_error   = (owner == OWN_MEM) && tmo;
    e_mem_ready   = !mem_valid || ((owner == OWN_MEM) && done);
    checkOutput("ext_valid", 32'(ext_valid), 32'(owner != NONE));
    if (owner != NONE)
      checkOutput("ext_address", ext_address, (owner == OWN_MEM) ? mem_address : cap_addr);
    checkOutput("ext_write", 32'(ext_write), 32'((owner == OWN_MEM) && mem_write));
    checkOutput("ext_write_strobe", 32'(ext_write_strobe),
                ((owner == OWN_MEM) && mem_write) ? 32'(mem_write_strobe) : 32'd0);
    if ((owner == OWN_MEM) && mem_write)
      checkOutput("ext_write_data", ext_write_data, mem_write_data);
    checkOutput("fetch_ready", 32'(fetch_ready), 32'(e_fetch_ready));
    checkOutput("fetch_error", 32'(fetch_error), 32'(e_fetch_error));
    checkOutput("mem_ready", 32'(mem_ready), 32'(e_mem_ready));
    checkOutput("mem_error", 32'(mem_error), 32'(e_mem_error));
    if (e_fetch_ready && !e_fetch_error)
      checkOutput("fetch_data", fetch_data, ext_read_data);
    if ((owner == OWN_MEM) && ext_ready && !mem_write)
      checkOutput("mem_data", mem_data, ext_read_data);

    nx_owner = owner; nx_dropped = dropped; nx_waited = waited + 1; nx_cap = cap_addr;
    if (owner == NONE) begin
      nx_waited = 0;
      if (mem_valid) begin
        nx_owner = OWN_MEM;
      end else if (fetch_valid && !fetch_abort) begin
        nx_owner = OWN_FETCH; nx_dropped = 1'b0; nx_cap = fetch_address;
      end
    end else if (done) begin
      nx_owner = NONE; nx_waited = 0;
    end else if ((owner == OWN_FETCH) && !dropped && fetch_abort) begin
      nx_dropped = 1'b1; nx_waited = 0;
    end
    if (!reset) begin
      nx_owner = NONE; nx_waited = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    owner = nx_owner; dropped = nx_dropped; waited = nx_waited; cap_addr = nx_cap;
  endtask

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; fetch_abort = 1'b0; fetch_address = '0;
    mem_valid = 1'b0; mem_address = '0; mem_write = 1'b0; mem_write_data = '0;
    mem_write_strobe = '0; ext_read_data = '0; ext_ready = 1'b0;

    // Reset values, including mem_ready following mem_valid
    applyStimulus();
    checkOutput("rst_mem_ready_idle", 32'(mem_ready), 32'd1);
    checkOutput("rst_ext_valid", 32'(ext_valid), 32'd0);
    advance();
    mem_valid = 1'b1;
    applyStimulus();
    checkOutput("rst_mem_ready_pending", 32'(mem_ready), 32'd0);
    advance();
    mem_valid = 1'b0; reset = 1'b1;
    applyStimulus();
    advance();

    // 1: plain fetch, bus answers on the second bus cycle
    fetch_valid = 1'b1; fetch_address = 32'h100;
    applyStimulus(); advance();
    applyStimulus();
    checkOutput("t1_addr", ext_address, 32'h100);
    checkOutput("t1_no_ready_yet", 32'(fetch_ready), 32'd0);
    advance();
    ext_ready = 1'b1; ext_read_data = 32'hCAFEF00D;
    applyStimulus();
    checkOutput("t1_fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("t1_fetch_data", fetch_data, 32'hCAFEF00D);
    advance();
    fetch_valid = 1'b0; ext_ready = 1'b0;
    applyStimulus(); advance();

    // 2: simultaneous requests, memory first
    fetch_valid = 1'b1; fetch_address = 32'h140;
    mem_valid = 1'b1; mem_address = 32'h8000; mem_write = 1'b0;
    applyStimulus(); advance();
    ext_ready = 1'b1; ext_read_data = 32'h1234_5678;
    applyStimulus();
    checkOutput("t2_mem_first", ext_address, 32'h8000);
    checkOutput("t2_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t2_mem_data", mem_data, 32'h1234_5678);
    advance();
    mem_valid = 1'b0; ext_ready = 1'b0;
    applyStimulus(); advance();
    applyStimulus();
    checkOutput("t2_fetch_second", ext_address, 32'h140);
    advance();
    ext_ready = 1'b1;
    applyStimulus(); advance();
    fetch_valid = 1'b0; ext_ready = 1'b0;
    applyStimulus(); advance();

    // 3: abort while in flight, result dropped, captured address held
    fetch_valid = 1'b1; fetch_address = 32'h200;
    applyStimulus(); advance();
    fetch_abort = 1'b1;
    applyStimulus(); advance();
    fetch_abort = 1'b0; fetch_valid = 1'b0; fetch_address = 32'h999;
    for (int i = 0; i < 3; i++) begin
      ext_ready = (i == 2);
      applyStimulus();
      checkOutput("t3_addr_held", ext_address, 32'h200);
      checkOutput("t3_no_ready", 32'(fetch_ready), 32'd0);
      advance();
    end
    ext_ready = 1'b0;
    applyStimulus();
    checkOutput("t3_idle", 32'(ext_valid), 32'd0);
    advance();

    // 4: store times out on the fourth bus cycle
    mem_valid = 1'b1; mem_write = 1'b1; mem_address = 32'h300;
    mem_write_data = 32'hA5A5_0001; mem_write_strobe = 4'b1111;
    applyStimulus(); advance();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput("t4_mem_ready", 32'(mem_ready), 32'(i == 4));
      checkOutput("t4_mem_error", 32'(mem_error), 32'(i == 4));
      advance();
    end
    mem_valid = 1'b0;
    applyStimulus();
    checkOutput("t4_ext_valid_after", 32'(ext_valid), 32'd0);
    advance();

    // 6: partial store strobes reach the bus
    mem_valid = 1'b1; mem_write = 1'b1; mem_write_strobe = 4'b0011;
    applyStimulus(); advance();
    ext_ready = 1'b1;
    applyStimulus();
    checkOutput("t6_strobe", 32'(ext_write_strobe), 32'h3);
    checkOutput("t6_write", 32'(ext_write), 32'd1);
    advance();
    mem_valid = 1'b0; mem_write = 1'b0; ext_ready = 1'b0;
    applyStimulus(); advance();

    // 5: reset in the middle of a memory access
    mem_valid = 1'b1; mem_address = 32'h500;
    applyStimulus(); advance();
    #1 reset = 1'b0;
    #1 checkOutput("t5_async_ext_valid", 32'(ext_valid), 32'd0);
    owner = NONE; waited = 0;
    applyStimulus(); advance();
    mem_valid = 1'b0; reset = 1'b1;
    fetch_valid = 1'b1; fetch_address = 32'h400;
    applyStimulus(); advance();
    ext_ready = 1'b1; ext_read_data = 32'h0BAD_F00D;
    applyStimulus();
    checkOutput("t5_fetch_after_reset", 32'(fetch_ready), 32'd1);
    advance();
    fetch_valid = 1'b0; ext_ready = 1'b0;
    applyStimulus(); advance();

    // Randomized traffic that obeys the requester handshake rules
    for (int c = 0; c < 600; c++) begin
      if (fetch_valid && (e_fetch_ready || fetch_abort)) begin
        fetch_valid = 1'(($urandom_range(0, 3)) != 0);
        fetch_address = $urandom();
      end else if (!fetch_valid) begin
        fetch_valid = 1'($urandom_range(0, 1));
        fetch_address = $urandom();
      end
      fetch_abort = fetch_valid && ($urandom_range(0, 7) == 0);
      if (mem_valid && e_mem_ready) begin
        mem_valid = 1'($urandom_range(0, 1));
      end else if (!mem_valid) begin
        mem_valid = ($urandom_range(0, 2) == 0);
      end
      if (mem_valid && e_mem_ready || !mem_valid) begin
        mem_address = $urandom(); mem_write = 1'($urandom_range(0, 1));
        mem_write_data = $urandom(); mem_write_strobe = 4'($urandom_range(0, 15));
      end
      ext_ready = ($urandom_range(0, 99) < 40);
      ext_read_data = $urandom();
      applyStimulus();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
